// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the FIFO write arbiter.
// Exposed as a function so the picker and any future variants agree exactly.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BURST
    } arb_state_t;

    // Widest requester vector the search function can handle.
    localparam int PICK_MAX = 32;
    localparam int PICK_IW  = 5;

    typedef struct packed {
        logic               found;
        logic [PICK_IW-1:0] index;
    } pick_t;

    // First set bit of valid, searching start, start+1, ... wrapping mod n_req.
    function automatic pick_t rr_pick(
        input logic [PICK_MAX-1:0] valid,
        input int                  n_req,
        input int                  start
    );
        pick_t              r;
        int                 idx;
        logic [PICK_IW-1:0] idx_w;
        r = '0;
        // Walk from the far end so the nearest hit to start overwrites the rest.
        for (int k = PICK_MAX - 1; k >= 0; k--) begin
            if (k < n_req) begin
                idx = start + k;
                if (idx >= n_req) begin
                    idx = idx - n_req;
                end
                idx_w = PICK_IW'(idx);
                if (valid[idx_w]) begin
                    r.found = 1'b1;
                    r.index = idx_w;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_rr_write_arbiter_picker.sv
// Combinational round-robin priority search over the requester valids,
// starting from a rotated position supplied by the arbiter.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int GW    = 2
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [GW-1:0]    start_i,
    output logic             found_o,
    output logic [GW-1:0]    index_o
);

    pick_t pick;

    always_comb begin
        pick = rr_pick(PICK_MAX'(valid_i), N_REQ, int'(start_i));
    end

    assign found_o = pick.found;
    assign index_o = GW'(pick.index);

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers,
// granting bursts of up to MAX_BURST beats and never writing while full.
module fifo_rr_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int N_REQ     = 3,
    parameter int MAX_BURST = 4,
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  logic [N_REQ*WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic                   fifo_full_i,
    output logic                   fifo_wr_en_o,
    output logic [WIDTH-1:0]       fifo_data_o,
    output logic                   grant_valid_o,
    output logic [GW-1:0]          grant_o
);

    arb_state_t    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] ptr_q,   ptr_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic [WIDTH-1:0] data_arr [N_REQ];
    logic [GW-1:0]    grant_inc;
    logic [GW-1:0]    pick_start;
    logic             pick_found;
    logic [GW-1:0]    pick_idx;
    logic             grant_req_valid;
    logic             beat;
    logic             last_beat;
    logic             burst_release;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data_i[i*WIDTH +: WIDTH];
    end

    assign grant_inc       = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + GW'(1);
    assign grant_req_valid = req_valid_i[grant_q];
    assign beat            = (state_q == ARB_BURST) && grant_req_valid && !fifo_full_i;
    assign last_beat       = (cnt_q == CW'(MAX_BURST - 1));
    // A stall on the final beat is not a release: the burst waits for room.
    assign burst_release   = (state_q == ARB_BURST) && (!grant_req_valid || (beat && last_beat));

    // Current grantee is searched last, so a lone producer keeps full throughput.
    assign pick_start = (state_q == ARB_IDLE) ? ptr_q : grant_inc;

    rr_picker #(
        .N_REQ (N_REQ),
        .GW    (GW)
    ) u_picker (
        .valid_i (req_valid_i),
        .start_i (pick_start),
        .found_o (pick_found),
        .index_o (pick_idx)
    );

    always_comb begin
        // NOTE: every next-state value gets a default first so no path infers a latch.
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d = ARB_BURST;
                    grant_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            ARB_BURST: begin
                if (burst_release) begin
                    ptr_d = grant_inc;
                    cnt_d = '0;
                    if (pick_found) begin
                        grant_d = pick_idx;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs stay zero in IDLE, which also covers the whole reset window.
    always_comb begin
        fifo_wr_en_o  = 1'b0;
        req_ready_o   = '0;
        fifo_data_o   = '0;
        grant_valid_o = 1'b0;
        grant_o       = '0;
        if (state_q == ARB_BURST) begin
            fifo_wr_en_o         = grant_req_valid && !fifo_full_i;
            req_ready_o[grant_q] = !fifo_full_i;
            fifo_data_o          = data_arr[grant_q];
            grant_valid_o        = 1'b1;
            grant_o              = grant_q;
        end
    end

endmodule
